// File: rtl/fir_core_rr_scheduler.sv
// Round-robin scheduler that time-shares one ap_ctrl_hs FIR core among NREQ requesters,
// sequencing the start/ready/done handshake and aborting hung transactions via a watchdog.
module fir_core_rr_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RES_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NREQ-1:0]          req_start,
    input  logic [NREQ*DATA_W-1:0]   req_x,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_err,
    output logic [RES_W-1:0]         req_y,
    output logic                     core_ap_start,
    input  logic                     core_ap_ready,
    input  logic                     core_ap_done,
    output logic [DATA_W-1:0]        core_x,
    input  logic [RES_W-1:0]         core_ap_return,
    output logic                     busy,
    output logic                     err_sticky,
    output logic [31:0]              txn_count
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StResp} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d, grant_q, grant_d, arb_idx, cand;
    logic                  arb_valid;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [DATA_W-1:0]     core_x_q, core_x_d;
    logic [RES_W-1:0]      req_y_q, req_y_d;
    logic [NREQ-1:0]       req_done_q, req_done_d, req_err_q, req_err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [31:0]           txn_count_q, txn_count_d;
    logic                  core_ap_start_q, busy_q;
    logic [DATA_W-1:0]     x_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_x_unpack
        assign x_arr[i] = req_x[i*DATA_W +: DATA_W];
    end

    // Lowest offset from the rr pointer wins; scanning downward lets it overwrite last.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % int'(NREQ));
            if (req_start[cand]) begin
                arb_valid = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        wdog_d       = wdog_q;
        core_x_d     = core_x_q;
        req_y_d      = req_y_q;
        req_done_d   = '0;
        req_err_d    = '0;
        err_sticky_d = err_sticky_q;
        txn_count_d  = txn_count_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d  = StStart;
                    grant_d  = arb_idx;
                    core_x_d = x_arr[arb_idx];
                    wdog_d   = '0;
                end
            end
            StStart, StWaitDone: begin
                // done on the expiry cycle still completes normally
                if (core_ap_done) begin
                    state_d             = StResp;
                    req_y_d             = core_ap_return;
                    req_done_d[grant_q] = 1'b1;
                    txn_count_d         = (txn_count_q != '1) ? txn_count_q + 32'd1
                                                              : txn_count_q;
                    ptr_d = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d            = StIdle;
                    req_err_d[grant_q] = 1'b1;
                    err_sticky_d       = 1'b1;
                    ptr_d = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                    if (state_q == StStart && core_ap_ready) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            grant_q         <= '0;
            wdog_q          <= '0;
            core_x_q        <= '0;
            req_y_q         <= '0;
            req_done_q      <= '0;
            req_err_q       <= '0;
            err_sticky_q    <= 1'b0;
            txn_count_q     <= '0;
            core_ap_start_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            grant_q         <= grant_d;
            wdog_q          <= wdog_d;
            core_x_q        <= core_x_d;
            req_y_q         <= req_y_d;
            req_done_q      <= req_done_d;
            req_err_q       <= req_err_d;
            err_sticky_q    <= err_sticky_d;
            txn_count_q     <= txn_count_d;
            core_ap_start_q <= (state_d == StStart);
            busy_q          <= (state_d == StStart) || (state_d == StWaitDone);
        end
    end

    assign req_done      = req_done_q;
    assign req_err       = req_err_q;
    assign req_y         = req_y_q;
    assign core_ap_start = core_ap_start_q;
    assign core_x        = core_x_q;
    assign busy          = busy_q;
    assign err_sticky    = err_sticky_q;
    assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_fir_core_rr_scheduler.sv
// Bench for fir_core_rr_scheduler: directed scenarios plus random traffic checked against a
// transaction-level round-robin model and a behavioural FIR core (result = 8 * sample).
module tb_fir_core_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int DATA_W  = 16;
    localparam int RES_W   = 32;
    localparam int TIMEOUT = 16;

    logic                   ap_clk = 1'b0;
    logic                   ap_rst_n;
    logic [NREQ-1:0]        req_start, req_done, req_err;
    logic [NREQ*DATA_W-1:0] req_x;
    logic [RES_W-1:0]       req_y, core_ap_return;
    logic                   core_ap_start, core_ap_ready, core_ap_done, busy, err_sticky;
    logic [DATA_W-1:0]      core_x;
    logic [31:0]            txn_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ptr  = 0;
    logic [31:0] exp_txn  = 0;
    logic [31:0] exp_y    = 0;
    int          core_lat = 3;
    int          core_gap = 0;
    bit          core_hang = 1'b0;
    bit          stray     = 1'b0;

    always #5 ap_clk = ~ap_clk;

    fir_core_rr_scheduler #(
        .NREQ(NREQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_start(req_start), .req_x(req_x), .req_done(req_done), .req_err(req_err),
        .req_y(req_y), .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done), .core_x(core_x), .core_ap_return(core_ap_return),
        .busy(busy), .err_sticky(err_sticky), .txn_count(txn_count)
    );

    function automatic logic [RES_W-1:0] fir_ref(input logic [DATA_W-1:0] x);
        return 32'(x) * 32'd8;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Behavioural core: ready at cycle core_lat of the transaction, done core_gap later.
    initial begin : core_model
        int cnt, lat_l, gap_l;
        bit active;
        cnt = 0; lat_l = 1; gap_l = 0; active = 1'b0;
        core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_return = '0;
        forever begin
            @(negedge ap_clk);
            core_ap_ready = 1'b0;
            core_ap_done  = 1'b0;
            if (!busy) active = 1'b0;
            else if (!active) begin
                active = 1'b1; cnt = 1; lat_l = core_lat; gap_l = core_gap;
            end else cnt++;
            if (active && cnt == lat_l) core_ap_ready = 1'b1;
            if (active && !core_hang && cnt == lat_l + gap_l) begin
                core_ap_done   = 1'b1;
                core_ap_return = 32'(core_x) * 32'd8;
            end
            if (stray) begin
                core_ap_done   = 1'b1;
                core_ap_return = 32'hDEAD;
            end
        end
    end

    task automatic apply_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ap_clk);
        n_checks++;
        if ({core_ap_start, busy, err_sticky} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {core_ap_start, busy, err_sticky});
        end
        n_checks++;
        if ({req_done, req_err} !== '0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0", {req_done, req_err});
        end
        n_checks++;
        if (req_y !== '0 || core_x !== '0) begin
            n_fail++; $display("FAIL reset_data: got y=%0h x=%0h expected 0", req_y, core_x);
        end
        n_checks++;
        if (txn_count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", txn_count);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (busy !== 1'b0 || core_ap_start !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: got busy=%b start=%b expected 0", busy, core_ap_start);
        end
    endtask

    task automatic test_single();
        int start_cycles = 0;
        int waited = 0;
        bit seen = 1'b0;
        core_lat = 3; core_gap = 0;
        req_x[0 +: DATA_W] = 16'd5;
        req_start = 4'b0001;
        while (!seen && waited < 50) begin
            @(negedge ap_clk); waited++;
            if (core_ap_start) start_cycles++;
            if (req_done !== '0) begin
                seen = 1'b1;
                n_checks++;
                if (req_done !== 4'b0001) begin
                    n_fail++; $display("FAIL t1_done: got %b expected 0001", req_done);
                end
                n_checks++;
                if (req_y !== 32'd40) begin
                    n_fail++; $display("FAIL t1_y: got %0d expected 40", req_y);
                end
                n_checks++;
                if (txn_count !== 32'd1) begin
                    n_fail++; $display("FAIL t1_count: got %0d expected 1", txn_count);
                end
                req_start = '0;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL t1_timeout: got no req_done expected one"); end
        n_checks++;
        if (start_cycles != 3) begin
            n_fail++; $display("FAIL t1_start_len: got %0d expected 3", start_cycles);
        end
        @(negedge ap_clk);
        n_checks++;
        if (req_done !== '0) begin
            n_fail++; $display("FAIL t1_pulse_width: got %b expected 0", req_done);
        end
        exp_ptr = 1; exp_txn = 1; exp_y = 32'd40;
    endtask

    task automatic test_fairness();
        int order[$];
        int want[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int grants[NREQ] = '{default: 0};
        logic [NREQ-1:0] reraise = '0;
        int waited = 0;
        apply_reset();
        exp_ptr = 0; exp_txn = 0;
        core_lat = 2; core_gap = 1;
        for (int i = 0; i < NREQ; i++) req_x[i*DATA_W +: DATA_W] = 16'(100 + i);
        req_start = 4'b1111;
        while (order.size() < 8 && waited < 400) begin
            @(negedge ap_clk); waited++;
            req_start = req_start | reraise;
            reraise = '0;
            if (req_done !== '0) begin
                int g = 0;
                for (int i = 0; i < NREQ; i++) if (req_done[i]) g = i;
                order.push_back(g);
                n_checks++;
                if (req_y !== fir_ref(16'(100 + g))) begin
                    n_fail++; $display("FAIL t2_y: got %0d expected %0d", req_y, fir_ref(16'(100 + g)));
                end
                req_start[g] = 1'b0;
                grants[g]++;
                if (grants[g] < 2) reraise[g] = 1'b1;
            end
        end
        n_checks++;
        if (order.size() != 8) begin
            n_fail++; $display("FAIL t2_timeout: got %0d grants expected 8", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            n_checks++;
            if (order[k] != want[k]) begin
                n_fail++; $display("FAIL t2_order[%0d]: got %0d expected %0d", k, order[k], want[k]);
            end
        end
        n_checks++;
        if (txn_count !== 32'd8) begin
            n_fail++; $display("FAIL t2_count: got %0d expected 8", txn_count);
        end
        exp_ptr = 0; exp_txn = 8; exp_y = fir_ref(16'd103);
    endtask

    task automatic test_same_cycle();
        int waited = 0;
        core_lat = 1; core_gap = 0;
        req_x[1*DATA_W +: DATA_W] = 16'h0123;
        req_start = 4'b0010;
        do begin @(negedge ap_clk); waited++; end while (!core_ap_start && waited < 20);
        n_checks++;
        if (!core_ap_start) begin n_fail++; $display("FAIL t3_start: got 0 expected 1"); end
        @(negedge ap_clk);
        exp_txn++; exp_y = fir_ref(16'h0123);
        n_checks++;
        if (req_done !== 4'b0010 || core_ap_start !== 1'b0) begin
            n_fail++; $display("FAIL t3_done: got %b/%b expected 0010/0", req_done, core_ap_start);
        end
        n_checks++;
        if (req_y !== exp_y || txn_count !== exp_txn) begin
            n_fail++; $display("FAIL t3_result: got %0h/%0d expected %0h/%0d", req_y, txn_count, exp_y, exp_txn);
        end
        req_start = '0;
        exp_ptr = 2;
        @(negedge ap_clk);
        n_checks++;
        if (req_done !== '0) begin n_fail++; $display("FAIL t3_pulse_width: got %b expected 0", req_done); end
    endtask

    task automatic test_watchdog();
        int n = 0;
        int waited = 0;
        core_lat = 2; core_gap = 0; core_hang = 1'b1;
        req_x[2*DATA_W +: DATA_W] = 16'h0AAA;
        req_x[3*DATA_W +: DATA_W] = 16'h0BBB;
        req_start = 4'b1100;
        do begin @(negedge ap_clk); waited++; end while (!core_ap_start && waited < 20);
        while (req_err === '0 && req_done === '0 && n < 3 * TIMEOUT) begin
            @(negedge ap_clk); n++;
        end
        n_checks++;
        if (n != TIMEOUT) begin n_fail++; $display("FAIL t4_latency: got %0d expected %0d", n, TIMEOUT); end
        n_checks++;
        if (req_err !== 4'b0100 || req_done !== '0) begin
            n_fail++; $display("FAIL t4_err: got err=%b done=%b expected 0100/0000", req_err, req_done);
        end
        n_checks++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL t4_sticky: got %b expected 1", err_sticky); end
        n_checks++;
        if (req_y !== exp_y || txn_count !== exp_txn) begin
            n_fail++; $display("FAIL t4_unchanged: got %0h/%0d expected %0h/%0d", req_y, txn_count, exp_y, exp_txn);
        end
        core_hang = 1'b0;
        req_start[2] = 1'b0;
        waited = 0;
        do begin @(negedge ap_clk); waited++; end while (req_done === '0 && waited < 40);
        exp_txn++; exp_y = fir_ref(16'h0BBB);
        n_checks++;
        if (req_done !== 4'b1000 || req_y !== exp_y) begin
            n_fail++; $display("FAIL t4_next: got %b/%0h expected 1000/%0h", req_done, req_y, exp_y);
        end
        req_start = '0;
        exp_ptr = 0;
        @(negedge ap_clk);
        n_checks++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL t4_sticky_hold: got %b expected 1", err_sticky); end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        logic [NREQ-1:0] pulses = '0;
        core_lat = 2; core_gap = 10;
        req_x[0 +: DATA_W] = 16'h0111;
        req_start = 4'b0001;
        do begin @(negedge ap_clk); waited++; end while (!(busy && !core_ap_start) && waited < 20);
        #2 ap_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_done, req_err, core_ap_start, busy, err_sticky} !== '0 || req_y !== '0 ||
            txn_count !== '0 || core_x !== '0) begin
            n_fail++; $display("FAIL t5_async: got busy=%b start=%b sticky=%b y=%0h cnt=%0d expected all 0",
                               busy, core_ap_start, err_sticky, req_y, txn_count);
        end
        req_start = '0;
        repeat (2) begin @(negedge ap_clk); pulses = pulses | req_done | req_err; end
        n_checks++;
        if (pulses !== '0) begin n_fail++; $display("FAIL t5_no_pulse: got %b expected 0", pulses); end
        ap_rst_n = 1'b1;
        core_gap = 0;
        req_x[2*DATA_W +: DATA_W] = 16'h0222;
        req_start = 4'b0100;
        waited = 0;
        do begin @(negedge ap_clk); waited++; end while (req_done === '0 && waited < 40);
        exp_txn = 1; exp_y = fir_ref(16'h0222); exp_ptr = 3;
        n_checks++;
        if (req_done !== 4'b0100 || txn_count !== exp_txn || req_y !== exp_y) begin
            n_fail++; $display("FAIL t5_after: got %b/%0d/%0h expected 0100/%0d/%0h",
                               req_done, txn_count, req_y, exp_txn, exp_y);
        end
        req_start = '0;
    endtask

    task automatic test_stray_done();
        logic [NREQ-1:0] pulses = '0;
        logic seen_busy = 1'b0;
        @(negedge ap_clk);
        stray = 1'b1;
        repeat (2) @(negedge ap_clk);
        stray = 1'b0;
        repeat (4) begin
            @(negedge ap_clk);
            pulses = pulses | req_done | req_err;
            seen_busy = seen_busy | busy;
        end
        n_checks++;
        if (pulses !== '0 || seen_busy !== 1'b0) begin
            n_fail++; $display("FAIL t6_quiet: got pulses=%b busy=%b expected 0/0", pulses, seen_busy);
        end
        n_checks++;
        if (req_y !== exp_y || txn_count !== exp_txn) begin
            n_fail++; $display("FAIL t6_unchanged: got %0h/%0d expected %0h/%0d", req_y, txn_count, exp_y, exp_txn);
        end
    endtask

    task automatic test_random_traffic(input int cycles);
        logic [NREQ-1:0]        snap_req = req_start;
        logic [NREQ*DATA_W-1:0] snap_x   = req_x;
        logic                   busy_prev = busy;
        logic [NREQ-1:0]        dropped;
        logic [DATA_W-1:0]      gx = '0;
        int g = 0;
        int ndone = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge ap_clk);
            dropped = '0;
            if (busy && !busy_prev) begin
                g = rr_pick(snap_req, exp_ptr);
                n_checks++;
                if (g < 0) begin
                    n_fail++; $display("FAIL rnd_spurious_grant: got busy expected idle");
                    g = 0;
                end else if (core_x !== snap_x[g*DATA_W +: DATA_W]) begin
                    n_fail++; $display("FAIL rnd_core_x: got %0h expected %0h", core_x, snap_x[g*DATA_W +: DATA_W]);
                end
                gx = snap_x[g*DATA_W +: DATA_W];
            end
            if (req_err !== '0) begin
                n_checks++; n_fail++;
                $display("FAIL rnd_err: got %b expected 0", req_err);
            end
            if (req_done !== '0) begin
                exp_txn++;
                exp_y = fir_ref(gx);
                n_checks++;
                if (req_done !== (4'b0001 << g)) begin
                    n_fail++; $display("FAIL rnd_grant: got %b expected %b", req_done, 4'b0001 << g);
                end
                n_checks++;
                if (req_y !== exp_y) begin
                    n_fail++; $display("FAIL rnd_y: got %0h expected %0h", req_y, exp_y);
                end
                n_checks++;
                if (txn_count !== exp_txn) begin
                    n_fail++; $display("FAIL rnd_count: got %0d expected %0d", txn_count, exp_txn);
                end
                exp_ptr = (g + 1) % NREQ;
                req_start[g] = 1'b0;
                dropped[g] = 1'b1;
                ndone++;
            end
            if (!busy) begin
                core_lat = int'($urandom_range(1, 4));
                core_gap = int'($urandom_range(0, 3));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_start[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
                    req_x[i*DATA_W +: DATA_W] = 16'($urandom);
                    req_start[i] = 1'b1;
                end
            end
            snap_req  = req_start;
            snap_x    = req_x;
            busy_prev = busy;
        end
        n_checks++;
        if (ndone < cycles / 12) begin
            n_fail++; $display("FAIL rnd_progress: got %0d transactions expected at least %0d", ndone, cycles / 12);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        ap_rst_n  = 1'b0;
        req_start = '0;
        req_x     = '0;
        test_reset();
        test_single();
        test_fairness();
        test_same_cycle();
        test_watchdog();
        test_reset_mid();
        test_stray_done();
        test_random_traffic(1500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
